reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_if.sv | 18 +
 rtl/reg_bank.sv | 44 ++++
 tb/tb_reg_bank.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// reg_bank_if: write port plus two combinational read ports of the register bank.
interface reg_bank_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int NB = WIDTH / 8;
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [NB-1:0]    wbe;
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    raddr2;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    modport master (output wen, waddr, wdata, wbe, raddr1, raddr2, input rdata1, rdata2);
    modport slave  (input wen, waddr, wdata, wbe, raddr1, raddr2, output rdata1, rdata2);
endinterface

// File: rtl/reg_bank.sv
// reg_bank: byte-lane register file, one write port, two bypassing read ports, optional hard-zero R0.
module reg_bank #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic        clk,
    input logic        rst,
    reg_bank_if.slave  bus
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] merged;
    logic             we;
    logic             rd1_ok;
    logic             rd2_ok;
    assign we = !rst && bus.wen && ({1'b0, bus.waddr} < DEPTH_W) && !(ZERO_REG == 1 && bus.waddr == '0);
    assign rd1_ok = ({1'b0, bus.raddr1} < DEPTH_W) && !(ZERO_REG == 1 && bus.raddr1 == '0);
    assign rd2_ok = ({1'b0, bus.raddr2} < DEPTH_W) && !(ZERO_REG == 1 && bus.raddr2 == '0);
    always_comb begin
        cur = we ? regs_q[bus.waddr] : '0;
        merged = cur;
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = bus.wbe[i] ? bus.wdata[8*i +: 8] : cur[8*i +: 8];
    end
    always_comb begin
        regs_d = regs_q;
        if (rst)
            for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
        else if (we)
            regs_d[bus.waddr] = merged;
    end
    always_ff @(posedge clk) regs_q <= regs_d;
    // Forwarding only fires when the write will actually commit, so reset and R0 never bypass.
    always_comb begin
        bus.rdata1 = !rd1_ok ? '0 : (BYPASS == 1 && we && bus.raddr1 == bus.waddr) ? merged : regs_q[bus.raddr1];
        bus.rdata2 = !rd2_ok ? '0 : (BYPASS == 1 && we && bus.raddr2 == bus.waddr) ? merged : regs_q[bus.raddr2];
    end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed checks on three builds (default, DEPTH=12, ZERO_REG=0/BYPASS=0) sharing one stimulus.
module tb_reg_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    reg_bank_if #(.WIDTH(16), .DEPTH(16)) ia ();
    reg_bank_if #(.WIDTH(16), .DEPTH(12)) ib ();
    reg_bank_if #(.WIDTH(16), .DEPTH(16)) ic ();
    reg_bank #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    reg_bank #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1), .BYPASS(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    reg_bank #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0), .BYPASS(0)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));
    always #5 clk = ~clk;

    task automatic drive(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        ia.wen = w; ia.waddr = a; ia.wdata = d; ia.wbe = be;
        ib.wen = w; ib.waddr = a; ib.wdata = d; ib.wbe = be;
        ic.wen = w; ic.waddr = a; ic.wdata = d; ic.wbe = be;
        #1;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        ia.raddr1 = a1; ia.raddr2 = a2;
        ib.raddr1 = a1; ib.raddr2 = a2;
        ic.raddr1 = a1; ic.raddr2 = a2;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        drive(1'b0, 4'd0, 16'h0, 2'b00);
        rd(4'd5, 4'd5);
        tick;
        rst = 1'b0;
        #1;
        chk("reset_a_r5", ia.rdata1, 16'h0000);
        chk("reset_c_r5", ic.rdata1, 16'h0000);
        drive(1'b1, 4'd5, 16'hBEEF, 2'b11);
        chk("bypass_a_p1", ia.rdata1, 16'hBEEF);
        chk("bypass_a_p2", ia.rdata2, 16'hBEEF);
        chk("nobypass_c_r5", ic.rdata1, 16'h0000);
        tick;
        drive(1'b0, 4'd5, 16'h0, 2'b00);
        chk("stored_a_r5", ia.rdata1, 16'hBEEF);
        chk("stored_c_r5", ic.rdata1, 16'hBEEF);
        // byte lanes on R3
        drive(1'b1, 4'd3, 16'h1234, 2'b11);
        rd(4'd3, 4'd3);
        tick;
        drive(1'b1, 4'd3, 16'hAB00, 2'b10);
        chk("lane_hi_bypass", ia.rdata1, 16'hAB34);
        chk("lane_hi_c_old", ic.rdata1, 16'h1234);
        tick;
        drive(1'b0, 4'd3, 16'h0, 2'b00);
        chk("lane_hi_stored", ia.rdata1, 16'hAB34);
        drive(1'b1, 4'd3, 16'h00CD, 2'b01);
        chk("lane_lo_bypass", ia.rdata2, 16'hABCD);
        tick;
        drive(1'b0, 4'd3, 16'h0, 2'b00);
        chk("lane_lo_stored_a", ia.rdata1, 16'hABCD);
        chk("lane_lo_stored_c", ic.rdata1, 16'hABCD);
        drive(1'b1, 4'd3, 16'hFFFF, 2'b00);
        chk("wbe0_bypass", ia.rdata1, 16'hABCD);
        tick;
        drive(1'b0, 4'd3, 16'h0, 2'b00);
        chk("wbe0_stored", ia.rdata1, 16'hABCD);
        // zero register
        rd(4'd0, 4'd0);
        drive(1'b1, 4'd0, 16'hFFFF, 2'b11);
        chk("zero_a_p1_wcyc", ia.rdata1, 16'h0000);
        chk("zero_a_p2_wcyc", ia.rdata2, 16'h0000);
        chk("zero_c_wcyc", ic.rdata1, 16'h0000);
        tick;
        drive(1'b0, 4'd0, 16'h0, 2'b00);
        chk("zero_a_p1_after", ia.rdata1, 16'h0000);
        chk("zero_a_p2_after", ia.rdata2, 16'h0000);
        chk("r0_plain_c", ic.rdata1, 16'hFFFF);
        chk("r0_plain_c_p2", ic.rdata2, 16'hFFFF);
        // out of range on the DEPTH=12 build
        drive(1'b1, 4'd1, 16'h0101, 2'b11);
        tick;
        rd(4'd13, 4'd1);
        drive(1'b1, 4'd13, 16'h7777, 2'b11);
        chk("oor_b_rd13_wcyc", ib.rdata1, 16'h0000);
        chk("oor_b_r1_wcyc", ib.rdata2, 16'h0101);
        chk("inr_a_bypass13", ia.rdata1, 16'h7777);
        tick;
        drive(1'b0, 4'd0, 16'h0, 2'b00);
        chk("oor_b_rd13", ib.rdata1, 16'h0000);
        chk("oor_b_r1", ib.rdata2, 16'h0101);
        chk("inr_a_r13", ia.rdata1, 16'h7777);
        // no-bypass latency
        drive(1'b1, 4'd9, 16'h1111, 2'b11);
        tick;
        rd(4'd0, 4'd9);
        drive(1'b1, 4'd9, 16'h4242, 2'b11);
        chk("nobyp_c_old", ic.rdata2, 16'h1111);
        chk("byp_a_new", ia.rdata2, 16'h4242);
        tick;
        drive(1'b0, 4'd0, 16'h0, 2'b00);
        chk("nobyp_c_new", ic.rdata2, 16'h4242);
        // reset priority over a same-cycle write
        drive(1'b1, 4'd7, 16'h5555, 2'b11);
        tick;
        rd(4'd7, 4'd9);
        drive(1'b0, 4'd0, 16'h0, 2'b00);
        chk("r7_pre", ia.rdata1, 16'h5555);
        rst = 1'b1;
        drive(1'b1, 4'd7, 16'h1111, 2'b11);
        chk("rst_no_bypass", ia.rdata1, 16'h5555);
        tick;
        rst = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 2'b00);
        chk("rst_r7_a", ia.rdata1, 16'h0000);
        chk("rst_r9_a", ia.rdata2, 16'h0000);
        chk("rst_r9_c", ic.rdata2, 16'h0000);
        // rst without a clock edge changes nothing
        drive(1'b1, 4'd2, 16'h2222, 2'b11);
        rd(4'd2, 4'd2);
        tick;
        drive(1'b0, 4'd0, 16'h0, 2'b00);
        rst = 1'b1;
        #1;
        chk("rst_no_edge", ia.rdata1, 16'h2222);
        tick;
        rst = 1'b0;
        #1;
        chk("rst_edge", ia.rdata1, 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
